// File: rtl/rv32i_data_memory.sv
// Word-organised data memory responding on the RV32I_Harvard CPU data port.
// Captures one request, waits WAIT_STATES cycles, then commits it and pulses mem_ready.
module rv32i_data_memory #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        async_reset,
  input  logic        memory_transaction,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_enablers,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        access_error
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t                  state, state_next;
  logic [3:0]              count;
  logic                    err_q;
  logic                    req_write;
  logic [31:0]             req_addr, req_wdata;
  logic [3:0]              req_be;
  logic                    acc_write;
  logic [31:0]             acc_addr, acc_wdata, offset;
  logic [3:0]              acc_be;
  logic                    access_now, access_ok, in_range;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [31:0]             mem [DEPTH];

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  endfunction

  // With zero wait states the access happens at the capture edge, so the live inputs stand in for the latch.
  always_comb begin
    acc_write = (state == IDLE) ? mem_write     : req_write;
    acc_addr  = (state == IDLE) ? address       : req_addr;
    acc_wdata = (state == IDLE) ? write_data    : req_wdata;
    acc_be    = (state == IDLE) ? byte_enablers : req_be;
    offset    = acc_addr - BASE_ADDR;
    word_idx  = offset[ADDR_WIDTH+1:2];
    in_range  = (acc_addr >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
    access_ok = in_range && (!acc_write || be_legal(acc_be));
  end

  always_comb begin
    state_next = state;
    access_now = 1'b0;
    case (state)
      IDLE: begin
        if (memory_transaction) begin
          if (WAIT_STATES == 0) begin
            access_now = 1'b1;
            state_next = RESPOND;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          access_now = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      err_q     <= 1'b0;
      read_data <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && memory_transaction)
        count <= WAIT_INIT;
      else if (state == WAIT && count != 4'd0)
        count <= count - 4'd1;
      if (access_now) begin
        err_q <= !access_ok;
        if (!acc_write)
          read_data <= access_ok ? mem[word_idx] : 32'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && memory_transaction) begin
      req_write <= mem_write;
      req_addr  <= address;
      req_wdata <= write_data;
      req_be    <= byte_enablers;
    end
  end

  always_ff @(posedge clock) begin
    if (access_now && acc_write && access_ok) begin
      for (int i = 0; i < 4; i++)
        if (acc_be[i]) mem[word_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
    end
  end

  assign mem_ready    = (state == RESPOND);
  assign access_error = (state == RESPOND) && err_q;

endmodule

// File: tb/tb_rv32i_data_memory.sv
// Directed bench for rv32i_data_memory: one instance with one wait state, one with none.
module tb_rv32i_data_memory;

  logic        clock = 1'b0;
  logic        async_reset = 1'b0;
  logic        mt = 1'b0, mw = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rdata;
  logic        ready, err;

  logic        z_mt = 1'b0, z_mw = 1'b0;
  logic [31:0] z_addr = '0, z_wdata = '0;
  logic [3:0]  z_be = '0;
  logic [31:0] z_rdata;
  logic        z_ready, z_err;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rv32i_data_memory #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut (
    .clock(clock), .async_reset(async_reset), .memory_transaction(mt), .mem_write(mw),
    .address(addr), .write_data(wdata), .byte_enablers(be),
    .read_data(rdata), .mem_ready(ready), .access_error(err));

  rv32i_data_memory #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clock(clock), .async_reset(async_reset), .memory_transaction(z_mt), .mem_write(z_mw),
    .address(z_addr), .write_data(z_wdata), .byte_enablers(z_be),
    .read_data(z_rdata), .mem_ready(z_ready), .access_error(z_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge while the one-wait-state instance is idle.
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic e,
                     output int lat);
    mt = 1'b1; mw = we; addr = a; wdata = d; be = b;
    @(posedge clock);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!ready && lat < 20);
    rd = rdata;
    e  = err;
    mt = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic zstore(input logic [31:0] a, input logic [31:0] d);
    z_mt = 1'b1; z_mw = 1'b1; z_addr = a; z_wdata = d; z_be = 4'b1111;
    @(posedge clock);
    @(negedge clock);
    chk("z_store_ready", {31'd0, z_ready}, 32'd1);
    z_mt = 1'b0;
    @(posedge clock); #1;
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat, pulses;
  logic [31:0] z_a [3];
  logic [31:0] z_v [3];

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_read_data", rdata, 32'd0);
    chk("rst_mem_ready", {31'd0, ready}, 32'd0);
    chk("rst_access_error", {31'd0, err}, 32'd0);
    async_reset = 1'b1;
    @(posedge clock); #1;

    // Full-word store then load
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, e, lat);
    chk("st10_latency", lat, 2);
    chk("st10_err", {31'd0, e}, 32'd0);
    chk("st10_rd_hold", rd, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, e, lat);
    chk("ld10_latency", lat, 2);
    chk("ld10_data", rd, 32'hDEADBEEF);
    chk("ld10_err", {31'd0, e}, 32'd0);

    // Byte-lane merge
    txn(1'b1, 32'h20, 32'h11223344, 4'b1111, rd, e, lat);
    txn(1'b1, 32'h20, 32'h000000AA, 4'b0001, rd, e, lat);
    chk("st20_rd_hold", rd, 32'hDEADBEEF);
    txn(1'b1, 32'h22, 32'hBBBB0000, 4'b1100, rd, e, lat);
    txn(1'b0, 32'h23, 32'h0, 4'b0101, rd, e, lat);
    chk("merge_data", rd, 32'hBBBB33AA);

    // Out-of-range load
    txn(1'b0, 32'd4096, 32'h0, 4'b1111, rd, e, lat);
    chk("oob_latency", lat, 2);
    chk("oob_err", {31'd0, e}, 32'd1);
    chk("oob_data", rd, 32'd0);

    // Illegal lane pattern on a store
    txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0101, rd, e, lat);
    chk("bad_be_err", {31'd0, e}, 32'd1);
    txn(1'b0, 32'h20, 32'h0, 4'b0000, rd, e, lat);
    chk("bad_be_unchanged", rd, 32'hBBBB33AA);
    chk("bad_be_next_err", {31'd0, e}, 32'd0);

    // Request dropped and redirected after capture
    txn(1'b1, 32'h40, 32'h55667788, 4'b1111, rd, e, lat);
    mt = 1'b1; mw = 1'b1; addr = 32'h44; wdata = 32'hCAFEF00D; be = 4'b1111;
    @(posedge clock); #1;
    mt = 1'b0; addr = 32'h40; wdata = 32'h0;
    pulses = 0;
    repeat (6) begin
      @(negedge clock);
      if (ready) pulses++;
    end
    chk("drop_pulses", pulses, 1);
    @(posedge clock); #1;
    txn(1'b0, 32'h44, 32'h0, 4'b0000, rd, e, lat);
    chk("drop_committed", rd, 32'hCAFEF00D);
    txn(1'b0, 32'h40, 32'h0, 4'b0000, rd, e, lat);
    chk("drop_untouched", rd, 32'h55667788);

    // Reset during WAIT of a store
    txn(1'b1, 32'h30, 32'h0, 4'b1111, rd, e, lat);
    mt = 1'b1; mw = 1'b1; addr = 32'h30; wdata = 32'h12345678; be = 4'b1111;
    @(posedge clock); #1;
    async_reset = 1'b0;
    #1;
    chk("wait_rst_ready", {31'd0, ready}, 32'd0);
    chk("wait_rst_read_data", rdata, 32'd0);
    chk("wait_rst_err", {31'd0, err}, 32'd0);
    mt = 1'b0;
    pulses = 0;
    @(posedge clock);
    @(negedge clock);
    if (ready) pulses++;
    async_reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (ready) pulses++;
    end
    chk("wait_rst_no_pulse", pulses, 0);
    @(posedge clock); #1;
    txn(1'b0, 32'h30, 32'h0, 4'b0000, rd, e, lat);
    chk("wait_rst_discard", rd, 32'h0);

    // Zero wait states, back-to-back loads
    z_a[0] = 32'h100; z_v[0] = 32'hA1A2A3A4;
    z_a[1] = 32'h104; z_v[1] = 32'hB1B2B3B4;
    z_a[2] = 32'h108; z_v[2] = 32'hC1C2C3C4;
    for (int k = 0; k < 3; k++) zstore(z_a[k], z_v[k]);
    z_mt = 1'b1; z_mw = 1'b0; z_addr = z_a[0]; z_be = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("z_ready_%0d", k), {31'd0, z_ready}, 32'd1);
      chk($sformatf("z_data_%0d", k), z_rdata, z_v[k]);
      z_addr = (k < 2) ? z_a[k+1] : 32'h200;
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("z_gap_%0d", k), {31'd0, z_ready}, 32'd0);
    end
    z_mt = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
